// File: rtl/bitplane_sort_engine.sv
// ---------------------------------------------------------------------------
// bitplane_sort_engine
//
// Sequential sorter that never compares two elements directly. A batch of up
// to ELEMENT_NUM unsigned values is buffered. Each scan walks the bit-planes
// from MSB to LSB and narrows an "event" mask of surviving candidates. The
// survivor with the lowest load slot is emitted and retired. This repeats
// until the batch is drained.
//
// Ports
//   clk          rising-edge clock for all state
//   rst_n        asynchronous active-low reset
//   i_in_valid   input element valid
//   o_in_ready   engine accepts input (LOAD state only)
//   i_in_data    element value
//   i_in_last    final element of the batch
//   i_desc       1 = largest first, 0 = smallest first; taken from the first
//                accepted element of a batch
//   o_out_valid  sorted element available
//   i_out_ready  downstream accepts the output
//   o_out_data   sorted value (0 when o_out_valid is low)
//   o_out_index  load slot of the emitted element (0 when o_out_valid is low)
//   o_out_last   final element of the batch (0 when o_out_valid is low)
// ---------------------------------------------------------------------------
module bitplane_sort_engine #(
    parameter  int ELEMENT_NUM = 16,
    parameter  int DATA_WIDTH  = 32,
    localparam int IDX_W       = $clog2(ELEMENT_NUM)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  i_in_valid,
    output logic                  o_in_ready,
    input  logic [DATA_WIDTH-1:0] i_in_data,
    input  logic                  i_in_last,
    input  logic                  i_desc,
    output logic                  o_out_valid,
    input  logic                  i_out_ready,
    output logic [DATA_WIDTH-1:0] o_out_data,
    output logic [IDX_W-1:0]      o_out_index,
    output logic                  o_out_last
);

    localparam int BIT_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
    localparam int CNT_W = $clog2(ELEMENT_NUM + 1);

    typedef enum logic [1:0] {
        S_LOAD,
        S_SCAN,
        S_EMIT
    } state_t;

    state_t r_state, w_state_next;

    logic [DATA_WIDTH-1:0]  r_data [ELEMENT_NUM];
    logic [ELEMENT_NUM-1:0] r_alive;
    logic [ELEMENT_NUM-1:0] r_evt;
    logic [IDX_W-1:0]       r_load_cnt;
    logic [CNT_W-1:0]       r_remaining;
    logic [BIT_W-1:0]       r_bit_idx;
    logic                   r_desc;

    logic                   w_accept;
    logic                   w_load_done;
    logic                   w_out_fire;
    logic                   w_batch_end;
    logic [ELEMENT_NUM-1:0] w_plane;
    logic [ELEMENT_NUM-1:0] w_hit;
    logic [ELEMENT_NUM-1:0] w_load_onehot;
    logic [ELEMENT_NUM-1:0] w_win_onehot;
    logic [IDX_W-1:0]       w_winner;

    assign w_accept    = i_in_valid & o_in_ready;
    assign w_load_done = w_accept & (i_in_last | (r_load_cnt == IDX_W'(ELEMENT_NUM - 1)));
    assign w_out_fire  = o_out_valid & i_out_ready;
    assign w_batch_end = (r_remaining == CNT_W'(1));

    // Per-slot plane bit. XOR with ~desc makes a '1' always mean "preferred":
    // descending prefers a set bit, ascending prefers a clear bit.
    generate
        for (genvar gi = 0; gi < ELEMENT_NUM; gi++) begin : g_slot
            assign w_plane[gi]       = r_data[gi][r_bit_idx] ^ ~r_desc;
            assign w_load_onehot[gi] = (r_load_cnt == IDX_W'(gi));
            assign w_win_onehot[gi]  = (w_winner == IDX_W'(gi));
        end
    endgenerate

    assign w_hit = w_plane & r_evt;

    // Lowest surviving slot wins, which gives stable ordering of equal values.
    always_comb begin
        w_winner = '0;
        for (int i = ELEMENT_NUM - 1; i >= 0; i--) begin
            if (r_evt[i]) w_winner = IDX_W'(i);
        end
    end

    // ---------------- FSM ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= S_LOAD;
        else        r_state <= w_state_next;
    end

    always_comb begin
        w_state_next = r_state;
        o_in_ready   = 1'b0;
        o_out_valid  = 1'b0;
        case (r_state)
            S_LOAD: begin
                o_in_ready = 1'b1;
                if (w_load_done) w_state_next = S_SCAN;
            end
            S_SCAN: begin
                if (r_bit_idx == '0) w_state_next = S_EMIT;
            end
            S_EMIT: begin
                o_out_valid = 1'b1;
                if (i_out_ready) w_state_next = w_batch_end ? S_LOAD : S_SCAN;
            end
            default: w_state_next = S_LOAD;
        endcase
    end

    // ---------------- Control state ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_alive     <= '0;
            r_evt       <= '0;
            r_load_cnt  <= '0;
            r_remaining <= '0;
            r_bit_idx   <= '0;
            r_desc      <= 1'b0;
        end else begin
            if (w_accept) begin
                r_alive <= r_alive | w_load_onehot;
                if (r_load_cnt == '0) r_desc <= i_desc;
                if (w_load_done) begin
                    // The slot written on this edge must join the first scan.
                    r_evt       <= r_alive | w_load_onehot;
                    r_bit_idx   <= BIT_W'(DATA_WIDTH - 1);
                    r_remaining <= CNT_W'(r_load_cnt) + CNT_W'(1);
                    r_load_cnt  <= '0;
                end else begin
                    r_load_cnt  <= r_load_cnt + IDX_W'(1);
                end
            end

            if (r_state == S_SCAN) begin
                // A plane where no candidate has the preferred bit cannot
                // discriminate, so the mask is left untouched.
                if (|w_hit) r_evt <= w_hit;
                r_bit_idx <= r_bit_idx - BIT_W'(1);
            end

            if (w_out_fire) begin
                r_alive     <= r_alive & ~w_win_onehot;
                r_evt       <= r_alive & ~w_win_onehot;
                r_remaining <= r_remaining - CNT_W'(1);
                r_bit_idx   <= BIT_W'(DATA_WIDTH - 1);
                if (w_batch_end) r_load_cnt <= '0;
            end
        end
    end

    // Element storage carries no reset; validity is tracked by r_alive.
    always_ff @(posedge clk) begin
        if (w_accept) r_data[r_load_cnt] <= i_in_data;
    end

    // ---------------- Outputs ----------------
    assign o_out_data  = o_out_valid ? r_data[w_winner] : '0;
    assign o_out_index = o_out_valid ? w_winner : '0;
    assign o_out_last  = o_out_valid & w_batch_end;

endmodule

// File: tb/tb_bitplane_sort_engine.sv
module tb_bitplane_sort_engine;

    localparam int EN = 4;
    localparam int DW = 8;
    localparam int IW = 2;

    logic          clk;
    logic          rst_n;
    logic          i_in_valid;
    logic          o_in_ready;
    logic [DW-1:0] i_in_data;
    logic          i_in_last;
    logic          i_desc;
    logic          o_out_valid;
    logic          i_out_ready;
    logic [DW-1:0] o_out_data;
    logic [IW-1:0] o_out_index;
    logic          o_out_last;

    bitplane_sort_engine #(.ELEMENT_NUM(EN), .DATA_WIDTH(DW)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .i_in_valid  (i_in_valid),
        .o_in_ready  (o_in_ready),
        .i_in_data   (i_in_data),
        .i_in_last   (i_in_last),
        .i_desc      (i_desc),
        .o_out_valid (o_out_valid),
        .i_out_ready (i_out_ready),
        .o_out_data  (o_out_data),
        .o_out_index (o_out_index),
        .o_out_last  (o_out_last)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [DW-1:0] d;
        logic [IW-1:0] idx;
        logic          last;
    } exp_t;

    exp_t          sb [$];
    int            n_checks   = 0;
    int            n_fail     = 0;
    int            hs_count   = 0;
    bit            last_hs_flag = 0;
    logic [DW-1:0] vals [EN];

    task automatic check_value(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Reference ordering: explicit max/min search, earliest slot wins ties.
    task automatic push_expected(input int n, input bit d);
        bit used [EN];
        for (int i = 0; i < EN; i++) used[i] = 0;
        for (int k = 0; k < n; k++) begin
            int best = -1;
            exp_t e;
            for (int i = 0; i < n; i++) begin
                if (!used[i]) begin
                    if (best < 0) best = i;
                    else if (d && vals[i] > vals[best]) best = i;
                    else if (!d && vals[i] < vals[best]) best = i;
                end
            end
            used[best] = 1;
            e.d    = vals[best];
            e.idx  = IW'(best);
            e.last = (k == n - 1);
            sb.push_back(e);
        end
    endtask

    // Output monitor: one line per output transaction, scoreboard compare.
    always @(negedge clk) begin
        if (rst_n && o_out_valid && i_out_ready) begin
            check_value("sb_avail", 32'(sb.size() > 0), 32'd1);
            if (sb.size() > 0) begin
                exp_t e;
                e = sb.pop_front();
                check_value("out_data", 32'(o_out_data), 32'(e.d));
                check_value("out_index", 32'(o_out_index), 32'(e.idx));
                check_value("out_last", 32'(o_out_last), 32'(e.last));
            end
            $display("OUT data=0x%02h index=%0d last=%0d", o_out_data, o_out_index, o_out_last);
            hs_count++;
            if (o_out_last) last_hs_flag = 1;
        end
    end

    // Loads vals[0..n-1]; optionally toggles desc mid-batch, keeps in_valid
    // asserted with junk during SCAN, or holds out_ready low at first EMIT.
    task automatic load_batch(input int n, input bit d, input bit toggle, input bit junk, input bit hold);
        int k;
        push_expected(n, d);
        for (int i = 0; i < n; i++) begin
            i_in_valid = 1'b1;
            i_in_data  = vals[i];
            i_in_last  = (i == n - 1);
            i_desc     = (toggle && i > 0) ? ~d : d;
            check_value("in_ready_load", 32'(o_in_ready), 32'd1);
            @(posedge clk); #1;
            $display("IN  data=0x%02h slot=%0d last=%0d desc=%0d", vals[i], i, (i == n - 1), i_desc);
        end
        i_in_valid = 1'b0;
        i_in_last  = 1'b0;
        if (toggle) i_desc = ~d;
        if (junk) begin
            i_in_valid = 1'b1;
            i_in_data  = 8'h77;
        end
        if (hold) i_out_ready = 1'b0;
        k = 0;
        for (int c = 0; c < 40; c++) begin
            if (junk) check_value("in_ready_scan", 32'(o_in_ready), 32'd0);
            @(posedge clk); #1;
            k++;
            if (o_out_valid) break;
        end
        i_in_valid = 1'b0;
        check_value("first_latency", 32'(k), 32'(DW));
    endtask

    task automatic wait_drain();
        bit done = 0;
        for (int c = 0; c < 300; c++) begin
            @(posedge clk); #1;
            if (last_hs_flag) begin
                last_hs_flag = 0;
                done = 1;
                check_value("in_ready_after_last", 32'(o_in_ready), 32'd1);
                break;
            end
        end
        check_value("drain_done", 32'(done), 32'd1);
        check_value("sb_empty", 32'(sb.size()), 32'd0);
    endtask

    initial begin
        int h0;
        bit seen;
        rst_n       = 1'b0;
        i_in_valid  = 1'b0;
        i_in_data   = '0;
        i_in_last   = 1'b0;
        i_desc      = 1'b0;
        i_out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check_value("rst_in_ready", 32'(o_in_ready), 32'd1);
        check_value("rst_out_valid", 32'(o_out_valid), 32'd0);
        check_value("rst_out_data", 32'(o_out_data), 32'd0);
        check_value("rst_out_index", 32'(o_out_index), 32'd0);
        check_value("rst_out_last", 32'(o_out_last), 32'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Descending full batch
        vals[0] = 8'h12; vals[1] = 8'hF0; vals[2] = 8'h07; vals[3] = 8'h80;
        load_batch(4, 1'b1, 1'b0, 1'b0, 1'b0);
        wait_drain();

        // Ascending, desc toggled during load and scan
        load_batch(4, 1'b0, 1'b1, 1'b0, 1'b0);
        wait_drain();

        // Duplicates, descending
        vals[0] = 8'h55; vals[1] = 8'h55; vals[2] = 8'h10; vals[3] = 8'h55;
        load_batch(4, 1'b1, 1'b0, 1'b0, 1'b0);
        wait_drain();

        // Partial batch with junk input during SCAN
        vals[0] = 8'h09; vals[1] = 8'h03;
        load_batch(2, 1'b0, 1'b0, 1'b1, 1'b0);
        wait_drain();

        // Backpressure at first EMIT
        vals[0] = 8'h3C; vals[1] = 8'hA5; vals[2] = 8'h00; vals[3] = 8'hFF;
        load_batch(4, 1'b1, 1'b0, 1'b0, 1'b1);
        for (int c = 0; c < 5; c++) begin
            @(posedge clk); #1;
            check_value("bp_valid", 32'(o_out_valid), 32'd1);
            check_value("bp_data", 32'(o_out_data), 32'(sb[0].d));
            check_value("bp_index", 32'(o_out_index), 32'(sb[0].idx));
            check_value("bp_last", 32'(o_out_last), 32'(sb[0].last));
        end
        i_out_ready = 1'b1;
        wait_drain();

        // Reset during SCAN of the second element
        vals[0] = 8'h12; vals[1] = 8'hF0; vals[2] = 8'h07; vals[3] = 8'h80;
        load_batch(4, 1'b1, 1'b0, 1'b0, 1'b0);
        h0 = hs_count;
        seen = 0;
        for (int c = 0; c < 40; c++) begin
            @(posedge clk); #1;
            if (hs_count != h0) begin
                seen = 1;
                break;
            end
        end
        check_value("first_hs_seen", 32'(seen), 32'd1);
        repeat (3) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check_value("midrst_out_valid", 32'(o_out_valid), 32'd0);
        check_value("midrst_out_data", 32'(o_out_data), 32'd0);
        check_value("midrst_out_last", 32'(o_out_last), 32'd0);
        check_value("midrst_in_ready", 32'(o_in_ready), 32'd1);
        sb.delete();
        last_hs_flag = 0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        vals[0] = 8'h01; vals[1] = 8'h02;
        load_batch(2, 1'b1, 1'b0, 1'b0, 1'b0);
        wait_drain();
        repeat (12) @(posedge clk);
        #1;
        check_value("idle_out_valid", 32'(o_out_valid), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
